// File: rtl/half_adder_dataflow_reg_if.sv
// rtl/half_adder_dataflow_reg_if.sv - lane operands, dataflow results and registered copy
// for the half adder cell.
interface half_adder_dataflow_reg_if #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_valid;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] carry_q;
   logic             out_valid;
   logic [CNT_W-1:0] carry_count;

   modport master (
      output a, b, in_valid,
      input  sum, carry, sum_q, carry_q, out_valid, carry_count
   );

   modport slave (
      input  a, b, in_valid,
      output sum, carry, sum_q, carry_q, out_valid, carry_count
   );
endinterface

// File: rtl/half_adder_dataflow_reg.sv
// rtl/half_adder_dataflow_reg.sv - per-lane half adder with a registered copy,
// valid flag and saturating carry-event counter.
module half_adder_dataflow_reg #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input logic                    clk,
   input logic                    rst,
   half_adder_dataflow_reg_if.slave bus
);
   logic [WIDTH-1:0] sum_r;
   logic [WIDTH-1:0] carry_r;
   logic             valid_r;
   logic [CNT_W-1:0] count_r;
   logic             any_carry;

   assign bus.sum   = bus.a ^ bus.b;
   assign bus.carry = bus.a & bus.b;
   assign any_carry = |(bus.a & bus.b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_r   <= '0;
         carry_r <= '0;
         valid_r <= 1'b0;
         count_r <= '0;
      end else begin
         valid_r <= bus.in_valid;
         if (bus.in_valid) begin
            sum_r   <= bus.a ^ bus.b;
            carry_r <= bus.a & bus.b;
         end
         // Stop at all-ones so a long debug run never wraps back to a small count.
         if (bus.in_valid && any_carry && (count_r != {CNT_W{1'b1}}))
            count_r <= count_r + 1'b1;
      end
   end

   assign bus.sum_q       = sum_r;
   assign bus.carry_q     = carry_r;
   assign bus.out_valid   = valid_r;
   assign bus.carry_count = count_r;
endmodule

// File: tb/tb_half_adder_dataflow_reg.sv
// tb/tb_half_adder_dataflow_reg.sv - directed and randomized checks of a 1-lane/8-bit-count
// and a 4-lane/2-bit-count instance against an arithmetic reference model.
`timescale 1ns/100ps
module tb_half_adder_dataflow_reg;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   half_adder_dataflow_reg_if #(.WIDTH(1), .CNT_W(8)) if1 ();
   half_adder_dataflow_reg_if #(.WIDTH(4), .CNT_W(2)) if4 ();

   half_adder_dataflow_reg #(.WIDTH(1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
   half_adder_dataflow_reg #(.WIDTH(4), .CNT_W(2)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference state: what each registered output should hold.
   logic [3:0] m1_sq, m1_cq, m4_sq, m4_cq;
   logic       m1_ov, m4_ov;
   int         m1_cnt, m4_cnt;

   // Per-lane arithmetic: a+b as an integer 0..2, sum is its low digit, carry its high digit.
   function automatic logic [3:0] ref_sum(input logic [3:0] x, input logic [3:0] y, input int w);
      logic [3:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[i] = ((int'(x[i]) + int'(y[i])) % 2) == 1;
      return r;
   endfunction

   function automatic logic [3:0] ref_carry(input logic [3:0] x, input logic [3:0] y, input int w);
      logic [3:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[i] = ((int'(x[i]) + int'(y[i])) / 2) == 1;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m1_sq = '0; m1_cq = '0; m1_ov = 1'b0; m1_cnt = 0;
      m4_sq = '0; m4_cq = '0; m4_ov = 1'b0; m4_cnt = 0;
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, " u1 sum_q"},   32'(if1.sum_q),       32'(m1_sq[0]));
      chk({tag, " u1 carry_q"}, 32'(if1.carry_q),     32'(m1_cq[0]));
      chk({tag, " u1 valid"},   32'(if1.out_valid),   32'(m1_ov));
      chk({tag, " u1 count"},   32'(if1.carry_count), 32'(m1_cnt));
      chk({tag, " u4 sum_q"},   32'(if4.sum_q),       32'(m4_sq));
      chk({tag, " u4 carry_q"}, 32'(if4.carry_q),     32'(m4_cq));
      chk({tag, " u4 valid"},   32'(if4.out_valid),   32'(m4_ov));
      chk({tag, " u4 count"},   32'(if4.carry_count), 32'(m4_cnt));
   endtask

   task automatic chk_comb(input string tag);
      chk({tag, " u1 sum"},   32'(if1.sum),   32'(ref_sum({3'b0, if1.a}, {3'b0, if1.b}, 1)));
      chk({tag, " u1 carry"}, 32'(if1.carry), 32'(ref_carry({3'b0, if1.a}, {3'b0, if1.b}, 1)));
      chk({tag, " u4 sum"},   32'(if4.sum),   32'(ref_sum(if4.a, if4.b, 4)));
      chk({tag, " u4 carry"}, 32'(if4.carry), 32'(ref_carry(if4.a, if4.b, 4)));
   endtask

   // One clocked cycle: drive between edges, check dataflow, take the edge, check registers.
   task automatic step(input string tag, input logic a1v, input logic b1v, input logic v1,
                       input logic [3:0] a4v, input logic [3:0] b4v, input logic v4);
      logic [3:0] c;
      if1.a = a1v; if1.b = b1v; if1.in_valid = v1;
      if4.a = a4v; if4.b = b4v; if4.in_valid = v4;
      #1;
      chk_comb(tag);
      @(posedge clk);
      m1_ov = v1;
      if (v1) begin
         m1_sq = ref_sum({3'b0, a1v}, {3'b0, b1v}, 1);
         c     = ref_carry({3'b0, a1v}, {3'b0, b1v}, 1);
         m1_cq = c;
         if (c != 0 && m1_cnt < 255) m1_cnt++;
      end
      m4_ov = v4;
      if (v4) begin
         m4_sq = ref_sum(a4v, b4v, 4);
         c     = ref_carry(a4v, b4v, 4);
         m4_cq = c;
         if (c != 0 && m4_cnt < 3) m4_cnt++;
      end
      #1;
      chk_regs(tag);
   endtask

   int sat_exp [5] = '{1, 2, 3, 3, 3};

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      if1.a = 1'b0; if1.b = 1'b0; if1.in_valid = 1'b0;
      if4.a = '0;   if4.b = '0;   if4.in_valid = 1'b0;
      model_clear();

      // Dataflow truth table with no clock edge involved.
      for (int i = 0; i < 5; i++) begin
         if1.a = (i == 2 || i == 3);
         if1.b = (i == 1 || i == 3);
         #0.5;
         chk("tt sum",   32'(if1.sum),   32'((i == 1 || i == 2) ? 1 : 0));
         chk("tt carry", 32'(if1.carry), 32'((i == 3) ? 1 : 0));
         #0.5;
      end

      // Held in reset with valid inputs: registers stay clear, dataflow stays live.
      if1.a = 1'b1; if1.b = 1'b1; if1.in_valid = 1'b1;
      if4.a = 4'hf; if4.b = 4'hf; if4.in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_regs("in reset");
      chk("in reset carry", 32'(if1.carry), 32'd1);
      chk("in reset u4 carry", 32'(if4.carry), 32'hf);
      rst = 1'b0;

      step("first capture", 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
      chk("first capture carry_q", 32'(if1.carry_q), 32'd1);
      chk("first capture count", 32'(if1.carry_count), 32'd1);

      // No valid: registered values hold, valid drops, count frozen.
      step("hold 0", 1'b0, 1'b1, 1'b0, 4'h5, 4'h3, 1'b0);
      step("hold 1", 1'b1, 1'b1, 1'b0, 4'hf, 4'hf, 1'b0);
      chk("hold carry_q", 32'(if1.carry_q), 32'd1);
      chk("hold valid", 32'(if1.out_valid), 32'd0);

      rst = 1'b1;
      #1;
      model_clear();
      chk_regs("async clear");
      rst = 1'b0;

      // 2-bit counter saturates at 3.
      for (int i = 0; i < 5; i++) begin
         step("sat", 1'b1, 1'b1, 1'b1, 4'h1, 4'h1, 1'b1);
         chk("sat count", 32'(if4.carry_count), 32'(sat_exp[i]));
      end

      step("lanes", 1'b0, 1'b0, 1'b0, 4'b1100, 4'b1010, 1'b1);
      chk("lanes sum", 32'(if4.sum), 32'b0110);
      chk("lanes carry_q", 32'(if4.carry_q), 32'b1000);

      // Reset asserted between edges clears registers without waiting for clk.
      #3;
      rst = 1'b1;
      #1;
      model_clear();
      chk_regs("mid-cycle rst");
      chk("mid-cycle rst live sum", 32'(if4.sum), 32'b0110);
      rst = 1'b0;
      #1;

      for (int i = 0; i < 60; i++) begin
         step("rand", 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
              1'($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
